// File: rtl/sw_txn_arbiter_pkg.sv
// ad_pkg: shared frame layout, FSM encoding and defaults for sw_txn_arbiter.
package ad_pkg;
    localparam int OP_LSB = 24;
    localparam int OP_W = 8;
    localparam int ADDR_LSB = 16;
    localparam int WDATA_LSB = 8;
    localparam int WR_BIT = 0;
    localparam int TIMEOUT_DEF = 16;
    typedef enum logic [2:0] {IDLE, POP, LOAD, ISSUE, DONE} arb_state_t;
endpackage

// File: rtl/sw_txn_arbiter_if.sv
// sw_txn_arbiter_if: FIFO-side and switch-side signals of the arbiter.
interface sw_txn_arbiter_if #(
    parameter int NUM_SW_INST = 5,
    parameter int W_WIDTH = 8,
    parameter int FRAME_WIDTH = 32
);
    logic [NUM_SW_INST-1:0] empty_in;
    logic [NUM_SW_INST*FRAME_WIDTH-1:0] frame_in;
    logic [NUM_SW_INST-1:0] ack_in;
    logic [W_WIDTH-1:0] rd_data_in;
    logic [NUM_SW_INST-1:0] fifo_rd_en;
    logic [NUM_SW_INST-1:0] sel_en;
    logic [W_WIDTH-1:0] addr_out;
    logic [W_WIDTH-1:0] wr_data_out;
    logic wr_rd_s_out;
    logic done_valid;
    logic [7:0] done_op_id;
    logic [W_WIDTH-1:0] rd_data_out;
    logic busy;
    logic timeout_err;
    modport master (
        input empty_in, frame_in, ack_in, rd_data_in,
        output fifo_rd_en, sel_en, addr_out, wr_data_out, wr_rd_s_out,
        output done_valid, done_op_id, rd_data_out, busy, timeout_err
    );
    modport slave (
        output empty_in, frame_in, ack_in, rd_data_in,
        input fifo_rd_en, sel_en, addr_out, wr_data_out, wr_rd_s_out,
        input done_valid, done_op_id, rd_data_out, busy, timeout_err
    );
endinterface

// File: rtl/sw_txn_arbiter_rr_pick.sv
// rr_pick: combinational round-robin search, first request at or above ptr with wrap.
module rr_pick #(
    parameter int N = 5,
    parameter int IW = 3
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt_oh,
    output logic [IW-1:0] gnt_idx
);
    logic [IW-1:0] j;
    always_comb begin
        gnt_oh = '0;
        gnt_idx = '0;
        j = '0;
        // Scan farthest-first so the closest hit to ptr is the last one written.
        for (int k = N - 1; k >= 0; k--) begin
            j = IW'((int'(ptr) + k) % N);
            if (req[j]) begin
                gnt_oh = N'(1) << j;
                gnt_idx = j;
            end
        end
    end
endmodule

// File: rtl/sw_txn_arbiter.sv
// sw_txn_arbiter: round-robin FIFO-to-switch transaction arbiter, one transaction outstanding.
// Define ARB_TIMEOUT_EN to abandon an unacknowledged ISSUE after TIMEOUT_CYCLES cycles.
module sw_txn_arbiter
    import ad_pkg::*;
#(
    parameter int NUM_SW_INST = 5,
    parameter int W_WIDTH = 8,
    parameter int FRAME_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
    input logic clk,
    input logic rst,
    sw_txn_arbiter_if.master bus
);
    localparam int IW = NUM_SW_INST > 1 ? $clog2(NUM_SW_INST) : 1;
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end
    arb_state_t state_q, state_d;
    logic [IW-1:0] grant_q, grant_d, rr_ptr_q, rr_ptr_d, pick_idx;
    logic [NUM_SW_INST-1:0] pick_oh, grant_oh;
    logic [OP_W-1:0] op_q, op_d, op_sel;
    logic [W_WIDTH-1:0] addr_q, addr_d, addr_sel, wdata_q, wdata_d, wdata_sel, rd_data_q, rd_data_d;
    logic wr_q, wr_d, wr_sel, ack_hit, tmo_hit, to_q;
    rr_pick #(.N(NUM_SW_INST), .IW(IW)) u_rr_pick (
        .req(~bus.empty_in),
        .ptr(rr_ptr_q),
        .gnt_oh(pick_oh),
        .gnt_idx(pick_idx)
    );
    assign grant_oh = NUM_SW_INST'(1) << grant_q;
    assign ack_hit = |(bus.ack_in & grant_oh);
`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic to_d;
    always_comb begin
        tmo_hit = state_q == ISSUE && tmo_cnt_q == CW'(TIMEOUT_CYCLES - 1);
        tmo_cnt_d = state_q == ISSUE && !ack_hit && !tmo_hit ? tmo_cnt_q + 1'b1 : '0;
        // An ack on the expiry edge wins over the timeout.
        to_d = state_q == ISSUE ? tmo_hit && !ack_hit : to_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_q <= '0;
            to_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            to_q <= to_d;
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign to_q = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            rr_ptr_q <= '0;
            op_q <= '0;
            addr_q <= '0;
            wdata_q <= '0;
            wr_q <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            op_q <= op_d;
            addr_q <= addr_d;
            wdata_q <= wdata_d;
            wr_q <= wr_d;
            rd_data_q <= rd_data_d;
        end
    end
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = |pick_oh ? POP : IDLE;
            POP:     state_d = LOAD;
            LOAD:    state_d = ISSUE;
            ISSUE:   state_d = ack_hit || tmo_hit ? DONE : ISSUE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        op_sel = '0;
        addr_sel = '0;
        wdata_sel = '0;
        wr_sel = 1'b0;
        for (int i = 0; i < NUM_SW_INST; i++) begin
            if (grant_q == IW'(i)) begin
                op_sel = bus.frame_in[i*FRAME_WIDTH+OP_LSB +: OP_W];
                addr_sel = bus.frame_in[i*FRAME_WIDTH+ADDR_LSB +: W_WIDTH];
                wdata_sel = bus.frame_in[i*FRAME_WIDTH+WDATA_LSB +: W_WIDTH];
                wr_sel = bus.frame_in[i*FRAME_WIDTH+WR_BIT];
            end
        end
        grant_d = state_q == IDLE && |pick_oh ? pick_idx : grant_q;
        rr_ptr_d = state_q != DONE ? rr_ptr_q : grant_q == IW'(NUM_SW_INST - 1) ? '0 : grant_q + 1'b1;
        op_d = state_q == LOAD ? op_sel : op_q;
        addr_d = state_q == LOAD ? addr_sel : addr_q;
        wdata_d = state_q == LOAD ? wdata_sel : wdata_q;
        wr_d = state_q == LOAD ? wr_sel : wr_q;
        rd_data_d = state_q != ISSUE ? rd_data_q : ack_hit ? bus.rd_data_in : tmo_hit ? '0 : rd_data_q;
    end
    always_comb begin
        bus.fifo_rd_en = state_q == POP ? grant_oh : '0;
        bus.sel_en = state_q == ISSUE ? grant_oh : '0;
        bus.addr_out = state_q == ISSUE ? addr_q : '0;
        bus.wr_data_out = state_q == ISSUE ? wdata_q : '0;
        bus.wr_rd_s_out = state_q == ISSUE && wr_q;
        bus.done_valid = state_q == DONE;
        bus.done_op_id = state_q == DONE ? op_q : '0;
        bus.timeout_err = state_q == DONE && to_q;
        bus.rd_data_out = rd_data_q;
        bus.busy = state_q != IDLE;
    end
endmodule
